// File: rtl/tan_pkg.sv
// Shared constants, state type and float helpers for the tangent range reducer.
package tan_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    localparam logic [31:0] PI_F      = 32'h40490fdb;
    localparam logic [31:0] HALF_PI_F = 32'h3fc90fdb;
    localparam logic [31:0] QNAN_F    = 32'h7fc00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SUB   = 2'd2,
        FIN   = 2'd3
    } state_e;

    function automatic logic [31:0] ftz(input logic [31:0] f);
        logic [31:0] r;
        r = f;
        if (f[30:23] == '0) r = {f[31], 31'b0};
        return r;
    endfunction

endpackage

// File: rtl/fp_add32.sv
// Combinational single-precision adder, round-to-nearest-even.
// Subnormal operands and results are flushed to signed zero.
module fp_add32
    import tan_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic               a_big;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [26:0]        mh;
    logic [26:0]        ml;
    logic [26:0]        mls;
    logic [26:0]        mask;
    logic [7:0]         d;
    logic [27:0]        s;
    logic [26:0]        n;
    logic [4:0]         lz;
    logic signed [9:0]  e;
    logic [24:0]        r;
    logic               rup;
    logic [MANT_W-1:0]  mant;

    always_comb begin
        a_big = a[30:0] >= b[30:0];
        hi    = a_big ? ftz(a) : ftz(b);
        lo    = a_big ? ftz(b) : ftz(a);
        mh    = {hi[30:23] != '0, hi[22:0], 3'b0};
        ml    = {lo[30:23] != '0, lo[22:0], 3'b0};
        d     = hi[30:23] - lo[30:23];
        mask  = '0;
        if (d >= 8'd27) begin
            mls = {26'b0, |ml};
        end else begin
            mask = ~({27{1'b1}} << d);
            mls  = ml >> d;
            mls[0] = mls[0] | (|(ml & mask));
        end
        if (hi[31] == lo[31]) s = {1'b0, mh} + {1'b0, mls};
        else                  s = {1'b0, mh} - {1'b0, mls};

        e  = $signed({2'b0, hi[30:23]});
        lz = '0;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end else begin
            n = s[26:0] << lz;
            e = e - $signed({5'b0, lz});
        end

        // Guard is n[2]; ties go to the even mantissa
        rup  = n[2] & ((n[1] | n[0]) | n[3]);
        r    = {1'b0, n[26:3]} + {24'b0, rup};
        mant = r[24] ? r[23:1] : r[22:0];
        if (r[24]) e = e + 10'sd1;

        if (s == '0)              sum = {hi[31] & lo[31], 31'b0};
        else if (e <= 10'sd0)     sum = {hi[31], 31'b0};
        else if (e >= 10'sd255)   sum = {hi[31], 8'hff, 23'b0};
        else                      sum = {hi[31], e[7:0], mant};
    end

endmodule

// File: rtl/tan_range_reduce.sv
// Folds an angle into [-pi/2, +pi/2] by repeated pi subtraction.
// Optional iter_count status port: define TAN_RR_ITER_STATUS_EN.
module tan_range_reduce #(
    parameter int          MAX_ITER  = 64,
    parameter logic [31:0] PI_F      = tan_pkg::PI_F,
    parameter logic [31:0] HALF_PI_F = tan_pkg::HALF_PI_F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_restart,
    input  logic [31:0] angle,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
`ifdef TAN_RR_ITER_STATUS_EN
    output logic [6:0]  iter_count,
`endif
    output logic        err
);

    import tan_pkg::*;

    localparam int CW = ($clog2(MAX_ITER + 1) > 7) ? $clog2(MAX_ITER + 1) : 7;

    state_e        state_q, state_d;
    logic [31:0]   x_q, x_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          perr_q, perr_d;
    logic          done_q, done_d;
    logic [31:0]   result_q, result_d;
    logic          err_q, err_d;
    logic [31:0]   sub_sum;

    fp_add32 u_add (
        .a   (x_q),
        .b   ({~x_q[31], PI_F[30:0]}),
        .sum (sub_sum)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        perr_d   = perr_q;
        done_d   = 1'b0;
        result_d = result_q;
        err_d    = err_q;
        if (start_restart) begin
            state_d = CHECK;
            x_d     = ftz(angle);
            cnt_d   = '0;
            perr_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                CHECK: begin
                    state_d = FIN;
                    if (x_q[30:23] == 8'hff) begin
                        x_d    = QNAN_F;
                        perr_d = 1'b1;
                    end else if (x_q[30:0] <= HALF_PI_F[30:0]) begin
                        perr_d = 1'b0;
                    end else if (cnt_q == CW'(MAX_ITER)) begin
                        perr_d = 1'b1;
                    end else begin
                        state_d = SUB;
                    end
                end
                SUB: begin
                    x_d     = sub_sum;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = CHECK;
                end
                FIN: begin
                    done_d   = 1'b1;
                    result_d = x_q;
                    err_d    = perr_q;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            cnt_q    <= '0;
            perr_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            perr_q   <= perr_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

`ifdef TAN_RR_ITER_STATUS_EN
    logic [6:0] iter_q, iter_d;

    always_comb begin
        iter_d = iter_q;
        if (!start_restart && state_q == FIN) iter_d = cnt_q[6:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) iter_q <= '0;
        else        iter_q <= iter_d;
    end

    assign iter_count = iter_q;
`endif

    assign busy   = state_q != IDLE;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_tan_range_reduce.sv
// Directed and random checks of tan_range_reduce against a real-arithmetic model.
module tb_tan_range_reduce;

    localparam logic [31:0] PI_B   = 32'h40490fdb;
    localparam logic [31:0] HALF_B = 32'h3fc90fdb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_restart = 1'b0;
    logic [31:0] angle = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;
`ifdef TAN_RR_ITER_STATUS_EN
    logic [6:0]  iter_count;
`endif

    int n_chk = 0;
    int n_fail = 0;

    tan_range_reduce dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_restart (start_restart),
        .angle         (angle),
        .busy          (busy),
        .done          (done),
        .result        (result),
`ifdef TAN_RR_ITER_STATUS_EN
        .iter_count    (iter_count),
`endif
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        e = 11'(f[30:23]) + 11'd896;
        if (f[30:23] == '0) d = {f[31], 63'b0};
        else                d = {f[31], e, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // Exact double result rounded once to single, nearest-even
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] q;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == '0) return {d[63], 31'b0};
        e = int'(d[62:52]) - 896;
        m = {1'b1, d[51:0]};
        q = {1'b0, m[52:29]};
        if (m[28] && ((|m[27:0]) || m[29])) q = q + 25'd1;
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        if (e <= 0)   return {d[63], 31'b0};
        if (e >= 255) return {d[63], 8'hff, 23'b0};
        return {d[63], 8'(e), q[22:0]};
    endfunction

    task automatic model(input logic [31:0] a, output logic [31:0] res,
                         output logic e, output int n);
        real xr;
        logic [31:0] x;
        n = 0;
        e = 1'b0;
        if (a[30:23] == 8'hff) begin
            res = 32'h7fc00000;
            e   = 1'b1;
            return;
        end
        x = (a[30:23] == 8'h00) ? {a[31], 31'b0} : a;
        while (1'b1) begin
            xr = f2r(x);
            if ((xr < 0.0 ? -xr : xr) <= f2r(HALF_B)) break;
            if (n == 64) begin
                e = 1'b1;
                break;
            end
            x = r2f(xr > 0.0 ? xr - f2r(PI_B) : xr + f2r(PI_B));
            n++;
        end
        res = x;
    endtask

    task automatic do_job(input string tag, input logic [31:0] a);
        logic [31:0] er;
        logic        ee;
        int          en;
        int          cyc;
        model(a, er, ee, en);
        @(negedge clk);
        start_restart = 1'b1;
        angle = a;
        @(posedge clk);
        #1;
        start_restart = 1'b0;
        chk({tag, ".busy"}, 64'(busy), 64'(1));
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".lat"}, 64'(cyc), 64'(2 + 2 * en));
        chk({tag, ".res"}, 64'(result), 64'(er));
        chk({tag, ".err"}, 64'(err), 64'(ee));
`ifdef TAN_RR_ITER_STATUS_EN
        chk({tag, ".iter"}, 64'(iter_count), 64'(en));
`endif
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 64'({done, busy}), 64'(0));
        chk({tag, ".hold"}, 64'({result, err}), 64'({er, ee}));
    endtask

    initial begin : main
        real diff;
        int  ndone;
        logic [31:0] ra;

        #2;
        chk("rst.out", 64'({busy, done, err, result}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        do_job("in_range", 32'h3fc00000);
        do_job("one_sub", 32'hc011361e);
        diff = f2r(result) - 0.872665;
        if (diff < 0.0) diff = -diff;
        n_chk++;
        assert (diff < 1e-6) else begin
            n_fail++;
            $error("FAIL one_sub.tol: observed %h expected ~0.872665", result);
        end
        do_job("max_iter", 32'h447a0000);
        do_job("inf", 32'h7f800000);
        do_job("nan", 32'hffc12345);
        do_job("denorm", 32'h80000001);
        do_job("pos_zero", 32'h00000000);
        do_job("half_pi", HALF_B);
        do_job("above_half", 32'h3fc90fdc);

        // Restart one cycle after the first start
        @(negedge clk);
        start_restart = 1'b1;
        angle = 32'h40800000;
        @(posedge clk);
        #1;
        angle = 32'h3f000000;
        @(posedge clk);
        #1;
        start_restart = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                ndone++;
                chk("restart.res", 64'(result), 64'h3f000000);
                chk("restart.lat", 64'(i), 64'(2));
            end
            @(posedge clk);
            #1;
        end
        chk("restart.ndone", 64'(ndone), 64'(1));

        // Reset while in SUB
        @(negedge clk);
        start_restart = 1'b1;
        angle = 32'h40800000;
        @(posedge clk);
        #1;
        start_restart = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.out", 64'({busy, done, err, result}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst.idle", 64'(busy), 64'(0));
        do_job("neg_zero", 32'h80000000);

        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            if (k % 6 == 5) ra[30:23] = 8'h00;
            else            ra[30:23] = 8'($urandom_range(120, 136));
            do_job($sformatf("rnd%0d", k), ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
